sample_mem_ctrl: RTL and testbench

- Record/playback sequencer for the 64K x 16 sample memory bank (4 x 16K SPRAM, 1-cycle registered read).
- Record mode: streams incoming audio samples into memory at consecutive addresses. Play mode: reads them back on request.
- Sole master of the bank's write/address/datain pins. Sits between the sample front-end and the bank.

---
 rtl/sample_mem_pkg.sv | 14 +
 rtl/sample_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sample_mem_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_mem_pkg.sv
// rtl/sample_mem_pkg.sv - shared types and constants for the sample memory sequencer
package sample_mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_DEPTH  = 65536;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/sample_mem_ctrl.sv
// rtl/sample_mem_ctrl.sv - record/playback sequencer in front of the 64K x 16 sample bank
module sample_mem_ctrl
    import sample_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter bit LOOP   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              play_req,
    output logic              play_valid,
    output logic [DATA_W-1:0] play_data,
    output logic              play_done,
    output logic              rec_full,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam logic [ADDR_W:0]   LAST_LEN = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0]   ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_PTR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    ctrl_state_t state;
    ctrl_state_t state_next;

    // wr_ptr counts issued writes and carries one extra bit so it saturates at
    // the depth instead of wrapping; rec_len counts writes the bank has taken.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_v1;
    logic              rd_v2;
    logic              rd_last;

    logic rec_go;
    logic play_go;
    logic wr_issue;
    logic rd_issue;
    logic rd_end;

    assign rd_end = (({1'b0, rd_ptr} + ONE_LEN) == rec_len);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle command decode; stop overrides everything but reset
    always_comb begin
        state_next = state;
        rec_go     = 1'b0;
        play_go    = 1'b0;
        wr_issue   = 1'b0;
        rd_issue   = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rec_start) begin
                        rec_go     = 1'b1;
                        state_next = RECORD;
                    end else if (play_start && (rec_len != '0)) begin
                        play_go    = 1'b1;
                        state_next = PLAY;
                    end
                end
                RECORD: begin
                    wr_issue = sample_valid && !wr_ptr[ADDR_W];
                    // The last word lands in the bank on this edge: memory is full.
                    if (mem_write && (rec_len == LAST_LEN)) begin
                        state_next = IDLE;
                    end
                end
                PLAY: begin
                    rd_issue = play_req && !rd_v1 && !rd_v2;
                    if (!LOOP && rd_v2 && rd_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Pointers, bank interface, read pipeline and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_last     <= 1'b0;
            rec_len     <= '0;
            rec_full    <= 1'b0;
            busy        <= 1'b0;
            play_valid  <= 1'b0;
            play_data   <= '0;
            play_done   <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_datain  <= '0;
        end else begin
            busy       <= (state_next != IDLE);
            mem_write  <= 1'b0;
            play_valid <= 1'b0;
            play_done  <= 1'b0;

            // A write presented last cycle is taken by the bank on this edge,
            // even if stop arrives now, so it always counts.
            if (mem_write) begin
                rec_len <= rec_len + ONE_LEN;
                if (rec_len == LAST_LEN) begin
                    rec_full <= 1'b1;
                end
            end

            if (rec_go) begin
                wr_ptr   <= '0;
                rec_len  <= '0;
                rec_full <= 1'b0;
            end

            if (play_go) begin
                rd_ptr  <= '0;
                rd_last <= 1'b0;
            end

            if (wr_issue) begin
                mem_write   <= 1'b1;
                mem_address <= wr_ptr[ADDR_W-1:0];
                mem_datain  <= sample_in;
                wr_ptr      <= wr_ptr + ONE_LEN;
            end

            // Two-stage read: address out, bank registers it, then capture data.
            rd_v1 <= rd_issue;
            rd_v2 <= rd_v1;
            if (rd_v2) begin
                play_data  <= mem_dataout;
                play_valid <= 1'b1;
                if (!LOOP && rd_last) begin
                    play_done <= 1'b1;
                    rd_last   <= 1'b0;
                end
            end

            if (rd_issue) begin
                mem_address <= rd_ptr;
                if (rd_end) begin
                    if (LOOP) begin
                        rd_ptr <= '0;
                    end else begin
                        rd_last <= 1'b1;
                    end
                end else begin
                    rd_ptr <= rd_ptr + ONE_PTR;
                end
            end

            // Abort discards any read in flight, including one completing now.
            if (stop) begin
                rd_v1      <= 1'b0;
                rd_v2      <= 1'b0;
                rd_last    <= 1'b0;
                play_valid <= 1'b0;
                play_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_mem_ctrl.sv
// tb/tb_sample_mem_ctrl.sv - self-checking bench for sample_mem_ctrl with behavioural banks
module tb_sample_mem_ctrl;
    import sample_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        rec_start = 1'b0;
    logic        play_start = 1'b0;
    logic        stop = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        play_req = 1'b0;

    logic        play_valid, play_done, rec_full, busy, mem_write;
    logic [15:0] play_data, mem_address, mem_datain, mem_dataout;
    logic [16:0] rec_len;

    logic        play_valid_l, play_done_l, rec_full_l, busy_l, mem_write_l;
    logic [15:0] play_data_l, mem_address_l, mem_datain_l, mem_dataout_l;
    logic [16:0] rec_len_l;

    int checks = 0;
    int passed = 0;

    logic [15:0] ref_mem [0:MEM_DEPTH-1];
    int          ref_len;

    sample_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .LOOP(1'b0)) dut (
        .clk(clk), .reset(reset), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .sample_valid(sample_valid), .sample_in(sample_in),
        .play_req(play_req), .play_valid(play_valid), .play_data(play_data),
        .play_done(play_done), .rec_full(rec_full), .rec_len(rec_len), .busy(busy),
        .mem_write(mem_write), .mem_address(mem_address), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout)
    );

    sample_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .LOOP(1'b1)) dut_l (
        .clk(clk), .reset(reset), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .sample_valid(sample_valid), .sample_in(sample_in),
        .play_req(play_req), .play_valid(play_valid_l), .play_data(play_data_l),
        .play_done(play_done_l), .rec_full(rec_full_l), .rec_len(rec_len_l), .busy(busy_l),
        .mem_write(mem_write_l), .mem_address(mem_address_l), .mem_datain(mem_datain_l),
        .mem_dataout(mem_dataout_l)
    );

    // Behavioural single-port banks with a one-cycle registered read
    logic [15:0] bank0 [0:MEM_DEPTH-1];
    logic [15:0] bank1 [0:MEM_DEPTH-1];
    always @(posedge clk) begin
        if (mem_write) bank0[mem_address] <= mem_datain;
        mem_dataout <= bank0[mem_address];
        if (mem_write_l) bank1[mem_address_l] <= mem_datain_l;
        mem_dataout_l <= bank1[mem_address_l];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
        sample_valid = 1'b0; play_req = 1'b0;
        tick; tick;
        reset = 1'b0;
        ref_len = 0;
    endtask

    task automatic pulse_rec;
        rec_start = 1'b1; tick; rec_start = 1'b0;
    endtask

    task automatic pulse_play;
        play_start = 1'b1; tick; play_start = 1'b0;
    endtask

    task automatic pulse_stop;
        stop = 1'b1; tick; stop = 1'b0;
    endtask

    task automatic record_list(input logic [15:0] d [$]);
        pulse_rec;
        foreach (d[k]) begin
            sample_valid = 1'b1; sample_in = d[k]; tick;
            ref_mem[k] = d[k];
        end
        sample_valid = 1'b0; tick; tick;
        ref_len = d.size();
        pulse_stop;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({busy, rec_full, play_valid, play_done, mem_write} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, rec_full, play_valid, play_done, mem_write});
        else passed++;
        checks++;
        if (rec_len !== 17'd0 || rec_len_l !== 17'd0 || mem_address !== 16'd0)
            $display("FAIL reset_len: got %0d/%0d addr %h expected 0/0 addr 0000", rec_len, rec_len_l, mem_address);
        else passed++;
    endtask

    task automatic test_record_play;
        logic [15:0] vals [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        do_reset;
        pulse_rec;
        checks++;
        if (busy !== 1'b1) $display("FAIL rec_busy: got %b expected 1", busy); else passed++;
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1; sample_in = vals[k]; tick;
            ref_mem[k] = vals[k];
            checks++;
            if (mem_write !== 1'b1 || mem_address !== 16'(k) || mem_datain !== vals[k])
                $display("FAIL rec_write%0d: got we=%b a=%h d=%h expected we=1 a=%h d=%h",
                         k, mem_write, mem_address, mem_datain, 16'(k), vals[k]);
            else passed++;
        end
        ref_len = 4;
        sample_valid = 1'b0; tick;
        checks++;
        if (mem_write !== 1'b0 || rec_len !== 17'(ref_len))
            $display("FAIL rec_len4: got we=%b len=%0d expected we=0 len=%0d", mem_write, rec_len, ref_len);
        else passed++;
        pulse_stop;
        pulse_play;
        checks++;
        if (busy !== 1'b1) $display("FAIL play_busy: got %b expected 1", busy); else passed++;
        for (int k = 0; k < ref_len; k++) begin
            play_req = 1'b1; tick; play_req = 1'b0; tick;
            checks++;
            if (play_valid !== 1'b0) $display("FAIL play_early%0d: got %b expected 0", k, play_valid); else passed++;
            tick;
            checks++;
            if (play_valid !== 1'b1 || play_data !== ref_mem[k] || play_done !== (k == ref_len - 1))
                $display("FAIL play%0d: got v=%b d=%h done=%b expected v=1 d=%h done=%b",
                         k, play_valid, play_data, play_done, ref_mem[k], (k == ref_len - 1));
            else passed++;
        end
        tick;
        checks++;
        if (busy !== 1'b0 || play_done !== 1'b0)
            $display("FAIL play_end: got busy=%b done=%b expected 0 0", busy, play_done);
        else passed++;
    endtask

    task automatic test_full;
        int extra_wr;
        extra_wr = 0;
        do_reset;
        pulse_rec;
        for (int i = 0; i < MEM_DEPTH + 5; i++) begin
            sample_valid = 1'b1;
            sample_in = (i < MEM_DEPTH) ? 16'(i) : 16'hDEAD;
            tick;
            if (i < MEM_DEPTH) begin
                ref_mem[i] = 16'(i);
                ref_len = i + 1;
            end else if (mem_write !== 1'b0) begin
                extra_wr++;
            end
            if (i == MEM_DEPTH) begin
                checks++;
                if (busy !== 1'b0 || rec_full !== 1'b1)
                    $display("FAIL full_idle: got busy=%b full=%b expected 0 1", busy, rec_full);
                else passed++;
            end
        end
        sample_valid = 1'b0; tick;
        checks++;
        if (extra_wr != 0 || rec_len !== 17'(ref_len) || rec_full !== 1'b1)
            $display("FAIL full_len: got extra=%0d len=%0d full=%b expected 0 %0d 1",
                     extra_wr, rec_len, rec_full, ref_len);
        else passed++;
        checks++;
        if (bank0[16'h3FFF] !== ref_mem[16'h3FFF] || bank0[16'h4000] !== ref_mem[16'h4000] ||
            bank0[16'hFFFF] !== ref_mem[16'hFFFF] || bank0[0] !== ref_mem[0])
            $display("FAIL full_spot: got %h %h %h %h expected 3fff 4000 ffff 0000",
                     bank0[16'h3FFF], bank0[16'h4000], bank0[16'hFFFF], bank0[0]);
        else passed++;
        pulse_play;
        for (int k = 0; k < 2; k++) begin
            play_req = 1'b1; tick; play_req = 1'b0; tick; tick;
            checks++;
            if (play_valid !== 1'b1 || play_data !== ref_mem[k])
                $display("FAIL full_play%0d: got v=%b d=%h expected v=1 d=%h", k, play_valid, play_data, ref_mem[k]);
            else passed++;
        end
        pulse_stop;
    endtask

    task automatic test_loop;
        logic [15:0] d [$];
        logic        done_seen;
        d = '{16'h000A, 16'h000B, 16'h000C};
        done_seen = 1'b0;
        do_reset;
        record_list(d);
        pulse_play;
        for (int k = 0; k < 7; k++) begin
            play_req = 1'b1; tick; play_req = 1'b0;
            done_seen |= play_done_l; tick;
            done_seen |= play_done_l; tick;
            done_seen |= play_done_l;
            checks++;
            if (play_valid_l !== 1'b1 || play_data_l !== ref_mem[k % ref_len])
                $display("FAIL loop%0d: got v=%b d=%h expected v=1 d=%h", k, play_valid_l, play_data_l, ref_mem[k % ref_len]);
            else passed++;
        end
        checks++;
        if (done_seen !== 1'b0 || busy_l !== 1'b1)
            $display("FAIL loop_done: got done=%b busy=%b expected 0 1", done_seen, busy_l);
        else passed++;
        pulse_stop;
    endtask

    task automatic test_stop_abort;
        logic [15:0] d [$];
        int          nvalid;
        logic [15:0] got;
        d = '{16'h000A, 16'h000B, 16'h000C};
        do_reset;
        record_list(d);
        pulse_play;
        play_req = 1'b1; tick; play_req = 1'b0;
        stop = 1'b1; tick; stop = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 3; k++) begin
            if (play_valid) nvalid++;
            tick;
        end
        checks++;
        if (nvalid != 0 || busy !== 1'b0 || rec_len !== 17'(ref_len))
            $display("FAIL stop_abort: got valids=%0d busy=%b len=%0d expected 0 0 %0d", nvalid, busy, rec_len, ref_len);
        else passed++;
        pulse_play;
        play_req = 1'b1; tick; tick; play_req = 1'b0;
        nvalid = 0; got = '0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (play_valid) begin nvalid++; got = play_data; end
        end
        checks++;
        if (nvalid != 1 || got !== ref_mem[0])
            $display("FAIL one_outstanding: got valids=%0d d=%h expected 1 d=%h", nvalid, got, ref_mem[0]);
        else passed++;
        pulse_stop;
    endtask

    task automatic test_priority;
        int bad;
        do_reset;
        stop = 1'b1; rec_start = 1'b1; tick; stop = 1'b0; rec_start = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL stop_over_rec: got busy=%b expected 0", busy); else passed++;
        rec_start = 1'b1; play_start = 1'b1; tick; rec_start = 1'b0; play_start = 1'b0;
        sample_valid = 1'b1; sample_in = 16'h5A5A; tick; sample_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_write !== 1'b1)
            $display("FAIL rec_over_play: got busy=%b we=%b expected 1 1", busy, mem_write);
        else passed++;
        do_reset;
        pulse_play;
        bad = 0;
        play_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (busy || play_valid || play_done || mem_write) bad++;
            tick;
        end
        play_req = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL play_empty: got %0d active cycles expected 0", bad); else passed++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        pulse_rec;
        sample_valid = 1'b1; sample_in = 16'h0101; tick; tick;
        reset = 1'b1; tick; reset = 1'b0; sample_valid = 1'b0;
        checks++;
        if (mem_write !== 1'b0 || rec_len !== 17'd0 || busy !== 1'b0)
            $display("FAIL reset_mid: got we=%b len=%0d busy=%b expected 0 0 0", mem_write, rec_len, busy);
        else passed++;
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(5, 30);
            do_reset;
            pulse_rec;
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                sample_valid = 1'b0;
                for (int g = 0; g < gap; g++) tick;
                sample_valid = 1'b1; sample_in = 16'($urandom); tick;
                ref_mem[k] = sample_in;
            end
            ref_len = n;
            sample_valid = 1'b0; tick;
            checks++;
            if (rec_len !== 17'(ref_len)) $display("FAIL rand_len%0d: got %0d expected %0d", it, rec_len, ref_len); else passed++;
            pulse_stop;
            pulse_play;
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick;
                play_req = 1'b1; tick; play_req = 1'b0; tick; tick;
                checks++;
                if (play_valid !== 1'b1 || play_data !== ref_mem[k] || play_done !== (k == n - 1))
                    $display("FAIL rand_play%0d_%0d: got v=%b d=%h done=%b expected v=1 d=%h done=%b",
                             it, k, play_valid, play_data, play_done, ref_mem[k], (k == n - 1));
                else passed++;
            end
            tick;
            checks++;
            if (busy !== 1'b0) $display("FAIL rand_idle%0d: got busy=%b expected 0", it, busy); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_record_play;
        test_full;
        test_loop;
        test_stop_abort;
        test_priority;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
